seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param.sv | 80 ++++++++
 tb/tb_seq_detector_param.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial-pattern detector.
// Shifts qualified serial bits into a history register and flags each time the
// last PATTERN_W bits equal the runtime-loadable pattern. Matching can overlap
// or restart from scratch after each hit; a saturating counter tallies hits.
module seq_detector_param #(
  parameter int                   PATTERN_W       = 3,
  parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = 3'b110,
  parameter int                   CNT_W           = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_bit,
  input  logic                 in_valid,
  input  logic                 overlap_en,
  input  logic                 pattern_load,
  input  logic [PATTERN_W-1:0] pattern_in,
  input  logic                 count_clr,
  output logic                 detected,
  output logic [CNT_W-1:0]     match_count,
  output logic                 count_sat
);

  // fill must be able to hold the value PATTERN_W itself
  localparam int                FILL_W    = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

  logic [PATTERN_W-1:0] pat;
  logic [PATTERN_W-1:0] hist;
  logic [PATTERN_W-1:0] hist_n;
  logic [FILL_W-1:0]    fill;
  logic [FILL_W-1:0]    fill_n;
  logic                 match;
  logic [CNT_W-1:0]     cnt_n;

  // Candidate history/fill for this sample, match decision and next counter value
  always_comb begin
    hist_n = {hist[PATTERN_W-2:0], in_bit};
    fill_n = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
    match  = in_valid && !pattern_load && (fill_n == FILL_FULL) && (hist_n == pat);

    cnt_n = match_count;
    if (count_clr) begin
      // a match landing in the same cycle as a clear is deliberately dropped
      cnt_n = '0;
    end else if (match && (match_count != {CNT_W{1'b1}})) begin
      cnt_n = match_count + 1'b1;
    end
  end

  // State registers: pattern, history, fill level, match flag and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pat         <= DEFAULT_PATTERN;
      hist        <= '0;
      fill        <= '0;
      detected    <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      match_count <= cnt_n;
      count_sat   <= &cnt_n;

      if (pattern_load) begin
        // new pattern: drop any partial history so stale bits cannot match
        pat      <= pattern_in;
        hist     <= '0;
        fill     <= '0;
        detected <= 1'b0;
      end else if (in_valid) begin
        hist     <= hist_n;
        detected <= match;
        // non-overlapping mode needs PATTERN_W fresh bits after a hit
        fill     <= (match && !overlap_en) ? '0 : fill_n;
      end else begin
        detected <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed testbench for seq_detector_param (PATTERN_W=3, CNT_W=2 so that
// counter saturation is reachable in a few samples).
module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       in_bit;
  logic       in_valid;
  logic       overlap_en;
  logic       pattern_load;
  logic [2:0] pattern_in;
  logic       count_clr;
  logic       detected;
  logic [1:0] match_count;
  logic       count_sat;

  int checks = 0;
  int errors = 0;

  seq_detector_param #(
    .PATTERN_W(3),
    .DEFAULT_PATTERN(3'b110),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_bit(in_bit),
    .in_valid(in_valid),
    .overlap_en(overlap_en),
    .pattern_load(pattern_load),
    .pattern_in(pattern_in),
    .count_clr(count_clr),
    .detected(detected),
    .match_count(match_count),
    .count_sat(count_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply inputs, let one rising edge pass, then settle 1 time unit past it.
  task automatic cyc(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    pattern_load = 1'b0;
    count_clr    = 1'b0;
    rst          = 1'b0;
  endtask

  // Load a pattern and clear the counter in the same cycle, no sample.
  task automatic load_clr(input logic [2:0] p);
    pattern_load = 1'b1;
    pattern_in   = p;
    count_clr    = 1'b1;
    cyc(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    checks++;
    if (detected !== 1'b0) begin
      errors++; $display("FAIL reset_detected: got %b want 0", detected);
    end
    checks++;
    if (match_count !== 2'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", match_count);
    end
    checks++;
    if (count_sat !== 1'b0) begin
      errors++; $display("FAIL reset_sat: got %b want 0", count_sat);
    end
  endtask

  task automatic test_default_110();
    logic b[6] = '{1, 1, 0, 1, 1, 0};
    logic e[6] = '{0, 0, 1, 0, 0, 1};
    overlap_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, b[i]);
      checks++;
      if (detected !== e[i]) begin
        errors++; $display("FAIL default110_det[%0d]: got %b want %b", i, detected, e[i]);
      end
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (detected !== 1'b0) begin
      errors++; $display("FAIL default110_idle: got %b want 0", detected);
    end
    checks++;
    if (match_count !== 2'd2) begin
      errors++; $display("FAIL default110_count: got %0d want 2", match_count);
    end
  endtask

  task automatic test_overlap_101();
    logic b[5]  = '{1, 0, 1, 0, 1};
    logic eo[5] = '{0, 0, 1, 0, 1};
    logic en[5] = '{0, 0, 1, 0, 0};
    load_clr(3'b101);
    overlap_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, b[i]);
      checks++;
      if (detected !== eo[i]) begin
        errors++; $display("FAIL overlap101_det[%0d]: got %b want %b", i, detected, eo[i]);
      end
    end
    checks++;
    if (match_count !== 2'd2) begin
      errors++; $display("FAIL overlap101_count: got %0d want 2", match_count);
    end
    load_clr(3'b101);
    overlap_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, b[i]);
      checks++;
      if (detected !== en[i]) begin
        errors++; $display("FAIL nooverlap101_det[%0d]: got %b want %b", i, detected, en[i]);
      end
    end
    checks++;
    if (match_count !== 2'd1) begin
      errors++; $display("FAIL nooverlap101_count: got %0d want 1", match_count);
    end
  endtask

  task automatic test_valid_gaps();
    logic v[7] = '{1, 0, 1, 0, 0, 1, 0};
    logic b[7] = '{1, 0, 1, 1, 1, 0, 0};
    logic e[7] = '{0, 0, 0, 0, 0, 1, 0};
    load_clr(3'b110);
    overlap_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc(v[i], b[i]);
      checks++;
      if (detected !== e[i]) begin
        errors++; $display("FAIL gaps_det[%0d]: got %b want %b", i, detected, e[i]);
      end
    end
    checks++;
    if (match_count !== 2'd1) begin
      errors++; $display("FAIL gaps_count: got %0d want 1", match_count);
    end
  endtask

  task automatic test_saturate();
    logic       e[6]  = '{0, 0, 1, 1, 1, 1};
    logic [1:0] ec[6] = '{0, 0, 1, 2, 3, 3};
    logic       es[6] = '{0, 0, 0, 0, 1, 1};
    load_clr(3'b111);
    overlap_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1);
      checks++;
      if (detected !== e[i]) begin
        errors++; $display("FAIL sat_det[%0d]: got %b want %b", i, detected, e[i]);
      end
      checks++;
      if (match_count !== ec[i]) begin
        errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, match_count, ec[i]);
      end
      checks++;
      if (count_sat !== es[i]) begin
        errors++; $display("FAIL sat_flag[%0d]: got %b want %b", i, count_sat, es[i]);
      end
    end
    count_clr = 1'b1;
    cyc(1'b1, 1'b1);
    checks++;
    if (detected !== 1'b1) begin
      errors++; $display("FAIL clr_match_det: got %b want 1", detected);
    end
    checks++;
    if (match_count !== 2'd0) begin
      errors++; $display("FAIL clr_match_count: got %0d want 0", match_count);
    end
    checks++;
    if (count_sat !== 1'b0) begin
      errors++; $display("FAIL clr_match_sat: got %b want 0", count_sat);
    end
    cyc(1'b1, 1'b1);
    checks++;
    if (match_count !== 2'd1) begin
      errors++; $display("FAIL after_clr_count: got %0d want 1", match_count);
    end
  endtask

  task automatic test_midstream_reset();
    logic b[4] = '{0, 1, 1, 0};
    logic e[4] = '{0, 0, 0, 1};
    load_clr(3'b110);
    overlap_en = 1'b1;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    rst = 1'b1;
    cyc(1'b1, 1'b0);
    checks++;
    if (detected !== 1'b0) begin
      errors++; $display("FAIL midrst_det: got %b want 0", detected);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, b[i]);
      checks++;
      if (detected !== e[i]) begin
        errors++; $display("FAIL midrst_det[%0d]: got %b want %b", i, detected, e[i]);
      end
    end
    checks++;
    if (match_count !== 2'd1) begin
      errors++; $display("FAIL midrst_count: got %0d want 1", match_count);
    end
  endtask

  task automatic test_load_collision();
    logic b[5] = '{1, 1, 0, 1, 1};
    logic e[5] = '{0, 0, 0, 0, 1};
    overlap_en = 1'b1;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    pattern_load = 1'b1;
    pattern_in   = 3'b011;
    cyc(1'b1, 1'b0);
    checks++;
    if (detected !== 1'b0) begin
      errors++; $display("FAIL load_det: got %b want 0", detected);
    end
    checks++;
    if (match_count !== 2'd1) begin
      errors++; $display("FAIL load_keeps_count: got %0d want 1", match_count);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, b[i]);
      checks++;
      if (detected !== e[i]) begin
        errors++; $display("FAIL load_new_det[%0d]: got %b want %b", i, detected, e[i]);
      end
    end
    checks++;
    if (match_count !== 2'd2) begin
      errors++; $display("FAIL load_new_count: got %0d want 2", match_count);
    end
  endtask

  initial begin
    rst          = 1'b0;
    in_bit       = 1'b0;
    in_valid     = 1'b0;
    overlap_en   = 1'b1;
    pattern_load = 1'b0;
    pattern_in   = 3'b000;
    count_clr    = 1'b0;
    #2;
    test_reset();
    test_default_110();
    test_overlap_101();
    test_valid_gaps();
    test_saturate();
    test_midstream_reset();
    test_load_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
